// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, requester ids and word-alignment mask for the data-memory arbiter
package dmem_pkg;
  typedef enum logic {IDLE = 1'b0, DMA_LOCK = 1'b1} state_t;
  typedef enum logic {CORE = 1'b0, DMA = 1'b1} req_id_t;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CORE/DMA request+grant+read-return buses, dma_lock, Data_Memory A/WD/WE/RD and misalign_err; slave=arbiter, master=requesters+memory
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              core_req, core_we, core_gnt, core_rvalid;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid, dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD, mem_RD;
  logic              mem_WE, misalign_err;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata, dma_lock, mem_RD,
    output core_gnt, core_rdata, core_rvalid, dma_gnt, dma_rdata, dma_rvalid, mem_A, mem_WD, mem_WE, misalign_err
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_addr, dma_wdata, dma_lock, mem_RD,
    input  core_gnt, core_rdata, core_rvalid, dma_gnt, dma_rdata, dma_rvalid, mem_A, mem_WD, mem_WE, misalign_err
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin picker (clk, rst, core_req, dma_req, dma_prio, force_core -> core_gnt, dma_gnt) with last_gnt register
module rr_arb2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic dma_req,
  input  logic dma_prio,
  input  logic force_core,
  output logic core_gnt,
  output logic dma_gnt
);
  req_id_t last_gnt;
  assign core_gnt = !rst && core_req && (force_core || !dma_req || (!dma_prio && last_gnt == DMA));
  assign dma_gnt  = !rst && dma_req && !force_core && (!core_req || dma_prio || last_gnt == CORE);
  always_ff @(posedge clk) begin
    if (rst) last_gnt <= DMA;
    else if (core_gnt) last_gnt <= CORE;
    else if (dma_gnt) last_gnt <= DMA;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares Data_Memory between CORE and DMA (clk, rst, bus: req/gnt/rdata/rvalid per requester, dma_lock, mem_A/WD/WE/RD, misalign_err)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  state_t            state, state_n;
  logic [CW-1:0]     lock_cnt, lock_cnt_n;
  logic              core_gnt, dma_gnt, any_gnt, force_core, sel_we, misalign;
  logic [ADDR_W-1:0] sel_addr, a_q;
  logic [DATA_W-1:0] sel_wd, wd_q;
  assign force_core = state == DMA_LOCK && lock_cnt == CW'(MAX_LOCK) && bus.core_req;
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .core_req  (bus.core_req),
    .dma_req   (bus.dma_req),
    .dma_prio  (state == DMA_LOCK),
    .force_core(force_core),
    .core_gnt  (core_gnt),
    .dma_gnt   (dma_gnt)
  );
  assign any_gnt      = core_gnt || dma_gnt;
  assign sel_addr     = dma_gnt ? bus.dma_addr : bus.core_addr;
  assign sel_wd       = dma_gnt ? bus.dma_wdata : bus.core_wdata;
  assign sel_we       = dma_gnt ? bus.dma_we : bus.core_we;
  assign misalign     = any_gnt && (sel_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  assign bus.core_gnt = core_gnt;
  assign bus.dma_gnt  = dma_gnt;
  assign bus.mem_A    = rst ? '0 : any_gnt ? sel_addr : a_q;
  assign bus.mem_WD   = rst ? '0 : any_gnt ? sel_wd : wd_q;
  assign bus.mem_WE   = any_gnt && sel_we && !misalign;
  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    if (state == IDLE) begin
      if (dma_gnt && bus.dma_lock) begin
        state_n    = DMA_LOCK;
        lock_cnt_n = CW'(1);
      end
    end else if (!bus.dma_lock) begin
      state_n    = IDLE;
      lock_cnt_n = '0;
    end else if (force_core) lock_cnt_n = '0;
    else if (dma_gnt && lock_cnt != CW'(MAX_LOCK)) lock_cnt_n = lock_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lock_cnt         <= '0;
      bus.core_rvalid  <= 1'b0;
      bus.dma_rvalid   <= 1'b0;
      bus.core_rdata   <= '0;
      bus.dma_rdata    <= '0;
      bus.misalign_err <= 1'b0;
      a_q              <= '0;
      wd_q             <= '0;
    end else begin
      state            <= state_n;
      lock_cnt         <= lock_cnt_n;
      bus.core_rvalid  <= core_gnt && !bus.core_we;
      bus.dma_rvalid   <= dma_gnt && !bus.dma_we;
      bus.misalign_err <= bus.misalign_err || misalign;
      if (core_gnt && !bus.core_we) bus.core_rdata <= bus.mem_RD;
      if (dma_gnt && !bus.dma_we) bus.dma_rdata <= bus.mem_RD;
      if (any_gnt) begin
        a_q  <= sel_addr;
        wd_q <= sel_wd;
      end
    end
  end
endmodule
